sipo_deserializer: RTL and testbench
====================================

// Module: sipo_deserializer
// PURPOSE
//  Serial-in/parallel-out receiver. It pairs with the team's parallel-load shift-out register.
//  - Collects BITS serial bits, LSB first, into a word.
//  - Presents the word on a registered output with a Valid/Ready handshake.
//  - Flags words lost while the output is still occupied.
//  Sits at the receiving end of a serial link, ahead of word-wide consumer logic.
// PARAMETERS
//  BITS  4  word width; legal values >= 2
//  CW    $clog2(BITS)  localparam: width of the bit counter
// PORTS
//  CLK      in   1     single clock; all state updates on posedge CLK
//  RST      in   1     reset, asynchronous, active-high; clears all state
//  SI       in   1     serial data bit; sampled only when Shift=1
//  Shift    in   1     bit strobe: accept SI this cycle
//  Clr      in   1     sync resync: discard the partial word, clear Overrun
//  Ready    in   1     consumer accepts Data this cycle when Valid=1
//  Data     out  BITS  last completed word (registered)
//  Valid    out  1     Data holds an unconsumed word
//  Count    out  CW    bits collected in the current partial word (0..BITS-1)
//  Overrun  out  1     sticky: a completed word was dropped
// BEHAVIOUR
//  - Reset values: sr=0, Count=0, Data=0, Valid=0, Overrun=0, state=EMPTY.
//  - Shift path (Shift=1, Clr=0):
//    - sr <= {SI, sr[BITS-1:1]}, so the first bit received ends up in Data[0].
//    - Count increments by 1. At BITS-1 it wraps to 0 and the word completes.
//  - Completion: completed word w = {SI, sr[BITS-1:1]}.
//    - Output FSM, 2 states:
//      - EMPTY (Valid=0)
//      - FULL (Valid=1)
//    - EMPTY + complete -> Data<=w, FULL.
//    - FULL + Ready + complete -> Data<=w, stay FULL. Back-to-back delivery, no bubble.
//    - FULL + ~Ready + complete -> Data unchanged, w dropped, Overrun<=1, stay FULL.
//    - FULL + Ready + no complete -> EMPTY. Data holds its last value.
//    - EMPTY + Ready: no effect.
//  - Latency: Valid rises in the cycle after the posedge that sampled the BITS-th strobe.
//  - Clr has priority over Shift in the same cycle:
//    - Count<=0 and sr<=0; that cycle's SI is discarded; Overrun<=0.
//    - Data, Valid and the FSM are unaffected, so Ready is still honoured that cycle.
//  - Shift=0: sr and Count hold, whatever SI does.
//  - RST asserted mid-word or while FULL: immediate async clear.
//    - The partial word and the pending word are both lost.
//    - Resume on the first posedge after RST deasserts.
//  - Overrun clears only on RST or Clr. A new valid word does not clear it.
// STRUCTURE
//  - Shared package registers_pkg holds:
//    - output FSM encodings ST_EMPTY=1'b0 and ST_FULL=1'b1
//    - a function for the counter width (clog2)
//  - Sub-module sipo_shift_core(BITS): the shift register sr plus the counter.
//    - Outputs: complete (1-cycle pulse), word, Count.
//  - Top level holds: the output register, the FSM, Overrun and the handshake.
// TESTING (BITS=4)
//  1 RST, then SI=1,1,0,1 with Shift on 4 consecutive cycles, Ready=0
//    -> after the 4th edge: Data=4'hB, Valid=1, Count=0, Overrun=0.
//  2 Continue from 1 with Ready=0. Shift in 0,0,1,0
//    -> Data stays 4'hB, Overrun=1, Valid=1.
//    Then Ready=1 for one cycle -> Valid=0, Overrun still 1.
//  3 Back-to-back: Ready held 1, send 4'h5 then 4'hA continuously
//    -> Valid stays 1 across the boundary; Data=5 then A; Overrun=0.
//  4 Shift in 1,1 (Count=2), then Clr=1 together with Shift and SI=1
//    -> Count=0. Then send 0,1,1,0 -> Data=4'h6.
//  5 Gapped strobes: Shift toggles every 3rd cycle, SI=1,0,0,1, with SI random between strobes
//    -> Data=4'h9.
//  6 Assert RST asynchronously mid-word (Count=3) and while Valid=1
//    -> all outputs 0 immediately, not waiting for a clock edge. The next word is received correctly.

Source files
------------

// File: rtl/registers_pkg.sv
// Shared types and helpers for the serial register family.
package registers_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/sipo_shift_core.sv
// Serial shift register and bit counter; flags the strobe that completes a word.
module sipo_shift_core
  import registers_pkg::*;
#(
  parameter  int unsigned BITS = 4,
  localparam int unsigned CW   = clog2(BITS)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            shift_i,
  input  logic            clr_i,
  input  logic            si_i,
  output logic            complete_c_o,
  output logic [BITS-1:0] word_c_o,
  output logic [CW-1:0]   count_o
);

  // Only the upper BITS-1 shift stages are kept; the lowest stage is never observed.
  logic [BITS-2:0] sr_q, sr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            last_c;

  assign last_c       = (count_q == CW'(BITS - 1));
  assign word_c_o     = {si_i, sr_q};
  assign complete_c_o = shift_i && !clr_i && last_c;
  assign count_o      = count_q;

  always_comb begin
    sr_d    = sr_q;
    count_d = count_q;
    if (clr_i) begin
      sr_d    = '0;
      count_d = '0;
    end else if (shift_i) begin
      sr_d    = word_c_o[BITS-1:1];
      count_d = last_c ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q    <= '0;
      count_q <= '0;
    end else begin
      sr_q    <= sr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out receiver: output word register, Valid/Ready handshake
// and sticky overrun flag on top of the shift core.
module sipo_deserializer
  import registers_pkg::*;
#(
  parameter  int unsigned BITS = 4,
  localparam int unsigned CW   = clog2(BITS)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SI,
  input  logic            Shift,
  input  logic            Clr,
  input  logic            Ready,
  output logic [BITS-1:0] Data,
  output logic            Valid,
  output logic [CW-1:0]   Count,
  output logic            Overrun
);

  logic            complete_c;
  logic [BITS-1:0] word_c;
  logic [BITS-1:0] data_q;
  logic            overrun_q;
  out_state_e      state_q;

  sipo_shift_core #(.BITS(BITS)) u_core (
    .clk_i       (CLK),
    .rst_i       (RST),
    .shift_i     (Shift),
    .clr_i       (Clr),
    .si_i        (SI),
    .complete_c_o(complete_c),
    .word_c_o    (word_c),
    .count_o     (Count)
  );

  // Output FSM; Clr only touches the overrun flag here, never the handshake.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_EMPTY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (Clr) overrun_q <= 1'b0;
      case (state_q)
        ST_EMPTY: begin
          if (complete_c) begin
            data_q  <= word_c;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (complete_c) begin
            if (Ready) data_q <= word_c;
            else       overrun_q <= 1'b1;
          end else if (Ready) begin
            state_q <= ST_EMPTY;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  assign Data    = data_q;
  assign Valid   = (state_q == ST_FULL);
  assign Overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (BITS=4) with a delivery scoreboard.
module tb_sipo_deserializer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SI = 1'b0, Shift = 1'b0, Clr = 1'b0, Ready = 1'b0;
  logic [3:0] Data;
  logic       Valid, Overrun;
  logic [1:0] Count;

  int compared   = 0;
  int mismatched = 0;
  logic [3:0] sb[$];

  sipo_deserializer #(.BITS(4)) dut (
    .CLK(CLK), .RST(RST), .SI(SI), .Shift(Shift), .Clr(Clr), .Ready(Ready),
    .Data(Data), .Valid(Valid), .Count(Count), .Overrun(Overrun)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; a handshake seen mid-cycle is checked against the scoreboard.
  task automatic tick();
    logic [3:0] e;
    @(negedge CLK);
    if (Valid === 1'b1 && Ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL sb_unexpected: observed delivery %0h expected none", Data);
      end else begin
        e = sb.pop_front();
        chk("sb_data", 32'(Data), 32'(e));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [3:0] w);
    Shift = 1'b1;
    for (int i = 0; i < 4; i++) begin
      SI = w[i];
      tick();
    end
    Shift = 1'b0;
  endtask

  initial begin
    logic [3:0] g;
    tick();
    tick();
    chk("rst_data", 32'(Data), 32'h0);
    chk("rst_valid", 32'(Valid), 32'h0);
    chk("rst_count", 32'(Count), 32'h0);
    chk("rst_overrun", 32'(Overrun), 32'h0);
    RST = 1'b0;

    // 1: first word, no consumer
    sb.push_back(4'hB);
    send_word(4'hB);
    chk("t1_data", 32'(Data), 32'hB);
    chk("t1_valid", 32'(Valid), 32'h1);
    chk("t1_count", 32'(Count), 32'h0);
    chk("t1_overrun", 32'(Overrun), 32'h0);

    // 2: second word dropped while full
    send_word(4'h4);
    chk("t2_data", 32'(Data), 32'hB);
    chk("t2_overrun", 32'(Overrun), 32'h1);
    chk("t2_valid", 32'(Valid), 32'h1);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    chk("t2_valid_after", 32'(Valid), 32'h0);
    chk("t2_overrun_sticky", 32'(Overrun), 32'h1);

    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    chk("clr_overrun", 32'(Overrun), 32'h0);

    // 3: back-to-back words; second completes while first is consumed
    sb.push_back(4'h5);
    sb.push_back(4'hA);
    send_word(4'h5);
    chk("t3_data5", 32'(Data), 32'h5);
    chk("t3_valid5", 32'(Valid), 32'h1);
    Shift = 1'b1;
    for (int i = 0; i < 4; i++) begin
      g = 4'hA;
      SI = g[i];
      Ready = (i == 3);
      tick();
    end
    Shift = 1'b0;
    chk("t3_dataA", 32'(Data), 32'hA);
    chk("t3_validA", 32'(Valid), 32'h1);
    chk("t3_overrun", 32'(Overrun), 32'h0);
    tick();
    Ready = 1'b0;
    chk("t3_drain", 32'(Valid), 32'h0);

    // 4: Clr mid-word beats Shift
    Shift = 1'b1;
    SI = 1'b1;
    tick();
    tick();
    chk("t4_count2", 32'(Count), 32'h2);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    Shift = 1'b0;
    chk("t4_count_clr", 32'(Count), 32'h0);
    sb.push_back(4'h6);
    send_word(4'h6);
    chk("t4_data", 32'(Data), 32'h6);
    Ready = 1'b1;
    Clr = 1'b1;
    tick();
    Ready = 1'b0;
    Clr = 1'b0;
    chk("t4_clr_ready", 32'(Valid), 32'h0);

    // 5: gapped strobes with noise between them
    g = 4'h9;
    sb.push_back(4'h9);
    for (int i = 0; i < 4; i++) begin
      Shift = 1'b1;
      SI = g[i];
      tick();
      Shift = 1'b0;
      if (i == 1) chk("t5_count_gap", 32'(Count), 32'h2);
      for (int k = 0; k < 2; k++) begin
        SI = 1'($urandom);
        tick();
      end
    end
    chk("t5_data", 32'(Data), 32'h9);
    chk("t5_valid", 32'(Valid), 32'h1);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;

    // 6: async reset while full, overrun set and mid-word
    send_word(4'h3);
    send_word(4'h7);
    Shift = 1'b1;
    SI = 1'b1;
    tick();
    tick();
    tick();
    Shift = 1'b0;
    chk("t6_count3", 32'(Count), 32'h3);
    chk("t6_pre_overrun", 32'(Overrun), 32'h1);
    #2 RST = 1'b1;
    #1;
    chk("t6_async_data", 32'(Data), 32'h0);
    chk("t6_async_valid", 32'(Valid), 32'h0);
    chk("t6_async_count", 32'(Count), 32'h0);
    chk("t6_async_overrun", 32'(Overrun), 32'h0);
    tick();
    RST = 1'b0;
    sb.push_back(4'hC);
    send_word(4'hC);
    chk("t6_data", 32'(Data), 32'hC);
    chk("t6_valid", 32'(Valid), 32'h1);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
